// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for the pet stat block.
//   - default stat width, ceiling and command step
//   - FSM state encoding for the timer initiator
//   - sat_update(): saturating stat update used by every stat register
package pet_pkg;

    localparam int STAT_W_DEF   = 4;
    localparam int STAT_MAX_DEF = 10;
    localparam int STEP_DEF     = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_UPDATE    = 3'd4
    } pet_state_t;

    // Decrement (floored at 0) is applied before the command add, so a
    // same-cycle decay and command gives min(max(s-1,0)+step, smax).
    function automatic int sat_update(input int s, input logic dec, input logic inc,
                                      input int step, input int smax);
        int t;
        t = s;
        if (dec && t > 0) t = t - 1;
        if (inc)          t = t + step;
        if (t > smax)     t = smax;
        return t;
    endfunction

endpackage

// File: rtl/pet_stat_decay.sv
// pet_stat_decay: ages the pet's hunger/energy/happiness stats once per
// completed period of an external 1 s one-shot timer.
//
// Timer handshake: tmr_init is a one-cycle arm request. The timer answers
// by raising tmr_busy while counting, then drops it and holds tmr_done high
// until the next arm. tmr_done is only trusted after tmr_busy has been seen,
// so a stale done left over from the previous run is never mistaken for a
// fresh completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            level, 1 = aging runs
//   feed/sleep/play   one-cycle command pulses (+STEP on hunger/energy/happy)
//   tmr_init          out, one-cycle arm request
//   tmr_busy          in, timer counting
//   tmr_done          in, sticky timer done flag
//   hunger/energy/happy  current stats
//   tick              one-cycle pulse per completed period
//   alarm             registered, 1 while any stat is 0
//   fsm_state         debug view of the initiator FSM
//   test_tick         only with PET_STAT_TEST_EN: forces an update cycle
//
// Optional feature macro: PET_STAT_TEST_EN (adds test_tick).
module pet_stat_decay
    import pet_pkg::*;
#(
    parameter int STAT_W        = STAT_W_DEF,
    parameter int STAT_MAX      = STAT_MAX_DEF,
    parameter int STEP          = STEP_DEF,
    parameter int HUNGER_PERIOD = 5,
    parameter int ENERGY_PERIOD = 7,
    parameter int HAPPY_PERIOD  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              feed,
    input  logic              sleep,
    input  logic              play,
`ifdef PET_STAT_TEST_EN
    input  logic              test_tick,
`endif
    output logic              tmr_init,
    input  logic              tmr_busy,
    input  logic              tmr_done,
    output logic [STAT_W-1:0] hunger,
    output logic [STAT_W-1:0] energy,
    output logic [STAT_W-1:0] happy,
    output logic              tick,
    output logic              alarm,
    output logic [2:0]        fsm_state
);

    pet_state_t state, state_n;
    logic       test_go;

`ifdef PET_STAT_TEST_EN
    assign test_go = test_tick;
`else
    assign test_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tmr_init = 1'b0;
        tick     = 1'b0;
        case (state)
            S_IDLE: begin
                if (test_go)     state_n = S_UPDATE;
                else if (enable) state_n = S_ARM;
            end
            S_ARM: begin
                tmr_init = 1'b1;
                state_n  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // tmr_done may still be high from the previous run here.
                if (test_go)       state_n = S_UPDATE;
                else if (tmr_busy) state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (test_go || tmr_done) state_n = S_UPDATE;
            end
            S_UPDATE: begin
                tick    = 1'b1;
                state_n = enable ? S_ARM : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign fsm_state = state;

    // Per-stat decay dividers: count ticks, fire on PERIOD-1 and wrap.
    logic [3:0] cnt_h, cnt_e, cnt_p;
    logic [3:0] cnt_h_n, cnt_e_n, cnt_p_n;
    logic       dec_h, dec_e, dec_p;

    assign dec_h = tick && (cnt_h == 4'(HUNGER_PERIOD - 1));
    assign dec_e = tick && (cnt_e == 4'(ENERGY_PERIOD - 1));
    assign dec_p = tick && (cnt_p == 4'(HAPPY_PERIOD - 1));

    always_comb begin
        cnt_h_n = cnt_h;
        cnt_e_n = cnt_e;
        cnt_p_n = cnt_p;
        if (tick) begin
            cnt_h_n = dec_h ? 4'd0 : cnt_h + 4'd1;
            cnt_e_n = dec_e ? 4'd0 : cnt_e + 4'd1;
            cnt_p_n = dec_p ? 4'd0 : cnt_p + 4'd1;
        end
    end

    logic [STAT_W-1:0] hunger_n, energy_n, happy_n;

    always_comb begin
        hunger_n = STAT_W'(sat_update(int'(hunger), dec_h, feed,  STEP, STAT_MAX));
        energy_n = STAT_W'(sat_update(int'(energy), dec_e, sleep, STEP, STAT_MAX));
        happy_n  = STAT_W'(sat_update(int'(happy),  dec_p, play,  STEP, STAT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h  <= 4'd0;
            cnt_e  <= 4'd0;
            cnt_p  <= 4'd0;
            hunger <= STAT_W'(STAT_MAX);
            energy <= STAT_W'(STAT_MAX);
            happy  <= STAT_W'(STAT_MAX);
            alarm  <= 1'b0;
        end else begin
            cnt_h  <= cnt_h_n;
            cnt_e  <= cnt_e_n;
            cnt_p  <= cnt_p_n;
            hunger <= hunger_n;
            energy <= energy_n;
            happy  <= happy_n;
            // Taken from the next-state values so alarm moves with the stats.
            alarm  <= (hunger_n == '0) || (energy_n == '0) || (happy_n == '0);
        end
    end

endmodule
